// File: rtl/caravel_hkspi_regs.sv
// Housekeeping SPI slave (mode 0, oversampled on the system clock) with the
// chip-ID, PLL and reset-control register file.
module caravel_hkspi_regs #(
    parameter logic [11:0] MFG_ID     = 12'h456,
    parameter logic [7:0]  PRODUCT_ID = 8'h20
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        sck,
    input  logic        csb,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    input  logic [31:0] user_id,
    input  logic        trap,
    output logic [1:0]  pll_ena,
    output logic        pll_bypass,
    output logic        irq,
    output logic        ext_reset,
    output logic [25:0] pll_trim,
    output logic [5:0]  pll_div,
    output logic [4:0]  pll_fb_div
);

    typedef enum logic [1:0] {IDLE, COMMAND, ADDRESS, DATA} state_t;

    state_t      state, state_next;
    logic [2:0]  sck_sync, csb_sync;
    logic [1:0]  sdi_sync;
    logic        sck_rise, sck_fall, csb_s, csb_fall, sdi_s;
    logic        active, byte_done, wr_en;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in, shift_out, rx_byte, addr, rd_addr, rd_data;
    logic        cmd_wr, cmd_rd, cmd_wr_dec, cmd_rd_dec;
    logic        sdo_q;

    // Bits [1:0] synchronize; bit [2] is the previous synchronized value.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sync <= '0;
            csb_sync <= '1;
            sdi_sync <= '0;
        end else begin
            sck_sync <= {sck_sync[1:0], sck};
            csb_sync <= {csb_sync[1:0], csb};
            sdi_sync <= {sdi_sync[0], sdi};
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign csb_s     = csb_sync[1];
    assign csb_fall  = ~csb_sync[1] & csb_sync[2];
    assign sdi_s     = sdi_sync[1];

    assign active     = (state != IDLE) && !csb_s && !csb_fall;
    assign byte_done  = active && sck_rise && (bit_cnt == 3'd7);
    assign rx_byte    = {shift_in[6:0], sdi_s};
    assign cmd_wr_dec = (rx_byte == 8'h80) || (rx_byte == 8'hC0);
    assign cmd_rd_dec = (rx_byte == 8'h40) || (rx_byte == 8'hC0);
    assign wr_en      = byte_done && (state == DATA) && cmd_wr;
    assign sdo_oe     = (state == DATA) && cmd_rd;
    assign sdo        = sdo_oe & sdo_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_next;
    end

    // Unrecognised commands park in DATA with both command flags clear.
    always_comb begin
        state_next = state;
        if (csb_s) begin
            state_next = IDLE;
        end else if (csb_fall) begin
            state_next = COMMAND;
        end else if (byte_done) begin
            case (state)
                COMMAND: state_next = (cmd_wr_dec || cmd_rd_dec) ? ADDRESS : DATA;
                ADDRESS: state_next = DATA;
                default: state_next = state;
            endcase
        end
    end

    // Read mux looks one byte ahead: the address byte itself, or the next address.
    assign rd_addr = (state == ADDRESS) ? rx_byte : addr + 8'd1;

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            8'h01: rd_data = {4'b0, MFG_ID[11:8]};
            8'h02: rd_data = MFG_ID[7:0];
            8'h03: rd_data = PRODUCT_ID;
            8'h04: rd_data = user_id[31:24];
            8'h05: rd_data = user_id[23:16];
            8'h06: rd_data = user_id[15:8];
            8'h07: rd_data = user_id[7:0];
            8'h08: rd_data = {6'b0, pll_ena};
            8'h09: rd_data = {7'b0, pll_bypass};
            8'h0a: rd_data = {7'b0, irq};
            8'h0b: rd_data = {7'b0, ext_reset};
            8'h0c: rd_data = {7'b0, trap};
            8'h0d: rd_data = pll_trim[7:0];
            8'h0e: rd_data = pll_trim[15:8];
            8'h0f: rd_data = pll_trim[23:16];
            8'h10: rd_data = {6'b0, pll_trim[25:24]};
            8'h11: rd_data = {2'b0, pll_div};
            8'h12: rd_data = {3'b0, pll_fb_div};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            addr      <= '0;
            cmd_wr    <= 1'b0;
            cmd_rd    <= 1'b0;
            sdo_q     <= 1'b0;
        end else if (csb_s) begin
            bit_cnt <= '0;
        end else if (csb_fall) begin
            bit_cnt <= '0;
            cmd_wr  <= 1'b0;
            cmd_rd  <= 1'b0;
        end else if (active) begin
            if (sck_rise) begin
                shift_in <= rx_byte;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        COMMAND: begin
                            cmd_wr <= cmd_wr_dec;
                            cmd_rd <= cmd_rd_dec;
                        end
                        ADDRESS: begin
                            addr <= rx_byte;
                            if (cmd_rd) shift_out <= rd_data;
                        end
                        DATA: begin
                            if (cmd_wr || cmd_rd) addr <= addr + 8'd1;
                            if (cmd_rd) shift_out <= rd_data;
                        end
                        default: ;
                    endcase
                end
            end else if (sck_fall && (state == DATA) && cmd_rd) begin
                sdo_q     <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            pll_ena    <= 2'b10;
            pll_bypass <= 1'b1;
            irq        <= 1'b0;
            ext_reset  <= 1'b0;
            pll_trim   <= 26'h3ffefff;
            pll_div    <= 6'h12;
            pll_fb_div <= 5'h04;
        end else if (wr_en) begin
            case (addr)
                8'h08: pll_ena          <= rx_byte[1:0];
                8'h09: pll_bypass       <= rx_byte[0];
                8'h0a: irq              <= rx_byte[0];
                8'h0b: ext_reset        <= rx_byte[0];
                8'h0d: pll_trim[7:0]    <= rx_byte;
                8'h0e: pll_trim[15:8]   <= rx_byte;
                8'h0f: pll_trim[23:16]  <= rx_byte;
                8'h10: pll_trim[25:24]  <= rx_byte[1:0];
                8'h11: pll_div          <= rx_byte[5:0];
                8'h12: pll_fb_div       <= rx_byte[4:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_caravel_hkspi_regs.sv
// Randomized self-checking bench for caravel_hkspi_regs against a byte-array
// register-map model driven by a bit-banged mode-0 SPI host.
module tb_caravel_hkspi_regs;

    logic        clock = 1'b0;
    logic        resetb, sck, csb, sdi, sdo, sdo_oe, trap;
    logic        pll_bypass, irq, ext_reset;
    logic [31:0] user_id;
    logic [1:0]  pll_ena;
    logic [25:0] pll_trim;
    logic [5:0]  pll_div;
    logic [4:0]  pll_fb_div;
    logic [41:0] dut_ports;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem   [0:255];
    logic [7:0] wmask [0:255];
    logic [7:0] tx_buf [0:31];
    logic [7:0] rx_buf [0:31];
    logic       rx_oe_all [0:31];
    logic       rx_oe_any [0:31];

    caravel_hkspi_regs dut (
        .clock(clock), .resetb(resetb), .sck(sck), .csb(csb), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .user_id(user_id), .trap(trap),
        .pll_ena(pll_ena), .pll_bypass(pll_bypass), .irq(irq), .ext_reset(ext_reset),
        .pll_trim(pll_trim), .pll_div(pll_div), .pll_fb_div(pll_fb_div)
    );

    always #5 clock = ~clock;

    assign dut_ports = {pll_ena, pll_bypass, irq, ext_reset, pll_trim, pll_div, pll_fb_div};

    task automatic model_reset;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = '0;
            wmask[i] = '0;
        end
        wmask[8'h08] = 8'h03; wmask[8'h09] = 8'h01; wmask[8'h0a] = 8'h01; wmask[8'h0b] = 8'h01;
        wmask[8'h0d] = 8'hff; wmask[8'h0e] = 8'hff; wmask[8'h0f] = 8'hff; wmask[8'h10] = 8'h03;
        wmask[8'h11] = 8'h3f; wmask[8'h12] = 8'h1f;
        mem[8'h08] = 8'h02; mem[8'h09] = 8'h01; mem[8'h0d] = 8'hff; mem[8'h0e] = 8'hef;
        mem[8'h0f] = 8'hff; mem[8'h10] = 8'h03; mem[8'h11] = 8'h12; mem[8'h12] = 8'h04;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        case (a)
            8'h01: return 8'h04;
            8'h02: return 8'h56;
            8'h03: return 8'h20;
            8'h04: return user_id[31:24];
            8'h05: return user_id[23:16];
            8'h06: return user_id[15:8];
            8'h07: return user_id[7:0];
            8'h0c: return {7'b0, trap};
            default: return mem[a];
        endcase
    endfunction

    function automatic logic [41:0] exp_ports();
        return {mem[8'h08][1:0], mem[8'h09][0], mem[8'h0a][0], mem[8'h0b][0],
                mem[8'h10][1:0], mem[8'h0f], mem[8'h0e], mem[8'h0d],
                mem[8'h11][5:0], mem[8'h12][4:0]};
    endfunction

    // Shifts tx_buf out MSB first; cut_bits >= 0 raises csb after that many bits.
    task automatic spi_txn(input int nbytes, input int cut_bits);
        int nbits;
        nbits = (cut_bits >= 0) ? cut_bits : nbytes * 8;
        csb = 1'b0;
        sck = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            int i;
            int b;
            i = k / 8;
            b = 7 - (k % 8);
            if (b == 7) begin
                rx_oe_all[i] = 1'b1;
                rx_oe_any[i] = 1'b0;
            end
            sdi = tx_buf[i][b];
            repeat (8) @(negedge clock);
            rx_buf[i][b] = sdo;
            if (sdo_oe !== 1'b1) rx_oe_all[i] = 1'b0;
            if (sdo_oe !== 1'b0) rx_oe_any[i] = 1'b1;
            sck = 1'b1;
            repeat (8) @(negedge clock);
            sck = 1'b0;
        end
        repeat (8) @(negedge clock);
        csb = 1'b1;
        sdi = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    task automatic do_reset;
        resetb = 1'b0;
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        repeat (3) @(negedge clock);
        model_reset();
    endtask

    task automatic test_reset;
        n_checks++; if (sdo_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sdo_oe: got %b expected 0", sdo_oe); end
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b expected 0", sdo); end
        n_checks++; if (pll_ena !== 2'b10) begin n_fail++; $display("FAIL reset_pll_ena: got %h expected 2", pll_ena); end
        n_checks++; if (pll_bypass !== 1'b1) begin n_fail++; $display("FAIL reset_pll_bypass: got %b expected 1", pll_bypass); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_checks++; if (ext_reset !== 1'b0) begin n_fail++; $display("FAIL reset_ext_reset: got %b expected 0", ext_reset); end
        n_checks++; if (pll_trim !== 26'h3ffefff) begin n_fail++; $display("FAIL reset_pll_trim: got %h expected 3ffefff", pll_trim); end
        n_checks++; if (pll_div !== 6'h12) begin n_fail++; $display("FAIL reset_pll_div: got %h expected 12", pll_div); end
        n_checks++; if (pll_fb_div !== 5'h04) begin n_fail++; $display("FAIL reset_pll_fb_div: got %h expected 04", pll_fb_div); end
    endtask

    task automatic test_id_read;
        logic [7:0] golden [0:18];
        golden = '{8'h00, 8'h04, 8'h56, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01,
                   8'h00, 8'h00, 8'h00, 8'hff, 8'hef, 8'hff, 8'h03, 8'h12, 8'h04};
        tx_buf[0] = 8'h40; tx_buf[1] = 8'h03; tx_buf[2] = 8'h00;
        spi_txn(3, -1);
        n_checks++; if (rx_buf[2] !== 8'h20) begin n_fail++; $display("FAIL product_id: got %h expected 20", rx_buf[2]); end
        n_checks++; if (rx_oe_all[2] !== 1'b1) begin n_fail++; $display("FAIL read_sdo_oe: got %b expected 1", rx_oe_all[2]); end
        n_checks++; if (rx_oe_any[1] !== 1'b0) begin n_fail++; $display("FAIL addr_phase_sdo_oe: got %b expected 0", rx_oe_any[1]); end
        tx_buf[0] = 8'h40; tx_buf[1] = 8'h00;
        for (int k = 2; k < 21; k++) tx_buf[k] = 8'h00;
        spi_txn(21, -1);
        for (int k = 0; k < 19; k++) begin
            n_checks++;
            if (rx_buf[k + 2] !== golden[k]) begin
                n_fail++; $display("FAIL map_read[%0h]: got %h expected %h", k, rx_buf[k + 2], golden[k]);
            end
        end
    endtask

    task automatic test_ext_reset;
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h0b; tx_buf[2] = 8'h01;
        spi_txn(3, -1);
        n_checks++; if (ext_reset !== 1'b1) begin n_fail++; $display("FAIL ext_reset_set: got %b expected 1", ext_reset); end
        n_checks++; if (rx_oe_any[2] !== 1'b0) begin n_fail++; $display("FAIL write_sdo_oe: got %b expected 0", rx_oe_any[2]); end
        tx_buf[2] = 8'h00;
        spi_txn(3, -1);
        n_checks++; if (ext_reset !== 1'b0) begin n_fail++; $display("FAIL ext_reset_clr: got %b expected 0", ext_reset); end
        tx_buf[0] = 8'h40;
        spi_txn(3, -1);
        n_checks++; if (rx_buf[2] !== 8'h00) begin n_fail++; $display("FAIL ext_reset_rd: got %h expected 00", rx_buf[2]); end
    endtask

    task automatic test_pll_trim;
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h0d;
        tx_buf[2] = 8'h11; tx_buf[3] = 8'h22; tx_buf[4] = 8'h33; tx_buf[5] = 8'h01;
        spi_txn(6, -1);
        n_checks++; if (pll_trim !== 26'h1332211) begin n_fail++; $display("FAIL pll_trim_wr: got %h expected 1332211", pll_trim); end
        tx_buf[0] = 8'h40;
        spi_txn(6, -1);
        n_checks++;
        if ({rx_buf[2], rx_buf[3], rx_buf[4], rx_buf[5]} !== 32'h11223301) begin
            n_fail++; $display("FAIL pll_trim_rd: got %h%h%h%h expected 11223301", rx_buf[2], rx_buf[3], rx_buf[4], rx_buf[5]);
        end
        do_reset();
        n_checks++; if (pll_trim !== 26'h3ffefff) begin n_fail++; $display("FAIL pll_trim_reset: got %h expected 3ffefff", pll_trim); end
    endtask

    task automatic test_wrap;
        tx_buf[0] = 8'h40; tx_buf[1] = 8'hfe;
        tx_buf[2] = 8'h00; tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
        spi_txn(5, -1);
        n_checks++;
        if ({rx_buf[2], rx_buf[3], rx_buf[4]} !== 24'h000000 || rx_oe_all[4] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_read: got %h%h%h oe %b expected 000000 oe 1", rx_buf[2], rx_buf[3], rx_buf[4], rx_oe_all[4]);
        end
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h03; tx_buf[2] = 8'h55;
        spi_txn(3, -1);
        tx_buf[0] = 8'h40;
        spi_txn(3, -1);
        n_checks++; if (rx_buf[2] !== 8'h20) begin n_fail++; $display("FAIL ro_write: got %h expected 20", rx_buf[2]); end
    endtask

    task automatic test_abort;
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h11; tx_buf[2] = 8'h2a;
        spi_txn(3, 20);
        n_checks++; if (pll_div !== 6'h12) begin n_fail++; $display("FAIL abort_pll_div: got %h expected 12", pll_div); end
        spi_txn(3, -1);
        n_checks++; if (pll_div !== 6'h2a) begin n_fail++; $display("FAIL after_abort_wr: got %h expected 2a", pll_div); end
        mem[8'h11] = 8'h2a;
        tx_buf[0] = 8'h40;
        spi_txn(3, -1);
        n_checks++; if (rx_buf[2] !== 8'h2a) begin n_fail++; $display("FAIL after_abort_rd: got %h expected 2a", rx_buf[2]); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            logic [7:0] cmd;
            logic [7:0] a;
            logic [7:0] ea;
            logic [7:0] exp_rd [0:7];
            logic       do_rd;
            logic       do_wr;
            int         n;
            int         sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0: cmd = 8'h80;
                1: cmd = 8'h40;
                2, 3: cmd = 8'hC0;
                default: cmd = 8'($urandom_range(0, 63));
            endcase
            do_wr = (cmd == 8'h80) || (cmd == 8'hC0);
            do_rd = (cmd == 8'h40) || (cmd == 8'hC0);
            a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(3, 19)) : 8'($urandom_range(0, 255));
            n = $urandom_range(1, 6);
            user_id = $urandom;
            trap = 1'($urandom_range(0, 1));
            tx_buf[0] = cmd;
            tx_buf[1] = a;
            for (int k = 0; k < n; k++) begin
                tx_buf[k + 2] = 8'($urandom);
                ea = a + 8'(k);
                exp_rd[k] = model_read(ea);
                if (do_wr) mem[ea] = tx_buf[k + 2] & wmask[ea];
            end
            spi_txn(n + 2, -1);
            for (int k = 0; k < n; k++) begin
                n_checks++;
                if (do_rd && (rx_buf[k + 2] !== exp_rd[k] || rx_oe_all[k + 2] !== 1'b1)) begin
                    n_fail++; $display("FAIL rand_rd t%0d cmd %h addr %h byte %0d: got %h oe %b expected %h oe 1",
                                       t, cmd, a, k, rx_buf[k + 2], rx_oe_all[k + 2], exp_rd[k]);
                end else if (!do_rd && rx_oe_any[k + 2] !== 1'b0) begin
                    n_fail++; $display("FAIL rand_oe t%0d cmd %h byte %0d: got oe 1 expected 0", t, cmd, k);
                end
            end
            n_checks++;
            if (dut_ports !== exp_ports()) begin
                n_fail++; $display("FAIL rand_ports t%0d cmd %h addr %h: got %h expected %h", t, cmd, a, dut_ports, exp_ports());
            end
        end
    endtask

    initial begin
        resetb  = 1'b0;
        csb     = 1'b1;
        sck     = 1'b0;
        sdi     = 1'b0;
        user_id = '0;
        trap    = 1'b0;
        model_reset();
        repeat (5) @(negedge clock);
        resetb = 1'b1;
        repeat (4) @(negedge clock);
        test_reset();
        test_id_read();
        test_ext_reset();
        test_pll_trim();
        test_wrap();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
